// File: rtl/mul_byte_seq_pkg.sv
// rtl/mul_byte_seq_pkg.sv - shared ALU constants for the sequential byte multiplier
package mul_byte_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_NEG  = 2'd3
    } mul_state_t;

    localparam int ITER_COUNT = 8;
    localparam int PRODUCT_W  = 16;

endpackage

// File: rtl/mul_byte_seq_if.sv
// rtl/mul_byte_seq_if.sv - launch/collect bus between ALU controller and multiplier (signed_op with MUL_SIGNED_EN)
interface mul_byte_seq_if;
    import mul_byte_seq_pkg::*;

    logic                 start;
    logic [7:0]           a;
    logic [7:0]           b;
`ifdef MUL_SIGNED_EN
    logic                 signed_op;
`endif
    logic                 busy;
    logic                 done;
    logic [PRODUCT_W-1:0] product;

`ifdef MUL_SIGNED_EN
    modport master (output start, a, b, signed_op, input busy, done, product);
    modport slave  (input start, a, b, signed_op, output busy, done, product);
`else
    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
`endif

endinterface

// File: rtl/adder_byte.sv
// rtl/adder_byte.sv - existing 8-bit ripple adder with carry in/out
module adder_byte (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};

endmodule

// File: rtl/mul_byte_seq.sv
// rtl/mul_byte_seq.sv - 8x8 shift-add multiplier on one adder_byte; MUL_SIGNED_EN adds signed operands
module mul_byte_seq
    import mul_byte_seq_pkg::*;
#(
    parameter int DONE_PULSE = 1
) (
    input  logic           clk,
    input  logic           rst,
    mul_byte_seq_if.slave  bus
);

    mul_state_t state;
    mul_state_t state_nxt;
    logic [7:0] mcand;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [3:0] count;
    logic [7:0] sum;
    logic       carry_out;
    logic       accept;
    logic [7:0] a_load;
    logic [7:0] b_load;
`ifdef MUL_SIGNED_EN
    logic       neg;
`endif

    assign accept = bus.start && (state == ST_IDLE || state == ST_DONE);

    // Signed mode works on magnitudes; the sign is reapplied in NEG.
`ifdef MUL_SIGNED_EN
    assign a_load = (bus.signed_op && bus.a[7]) ? (~bus.a + 8'd1) : bus.a;
    assign b_load = (bus.signed_op && bus.b[7]) ? (~bus.b + 8'd1) : bus.b;
`else
    assign a_load = bus.a;
    assign b_load = bus.b;
`endif

    adder_byte u_adder (
        .a         (hi),
        .b         (lo[0] ? mcand : 8'h00),
        .carry_in  (1'b0),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN: begin
                if (count == 4'(ITER_COUNT - 1)) begin
`ifdef MUL_SIGNED_EN
                    state_nxt = neg ? ST_NEG : ST_DONE;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
            ST_NEG:  state_nxt = ST_DONE;
            ST_DONE: begin
                if (accept) begin
                    state_nxt = ST_RUN;
                end else if (DONE_PULSE != 0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shift the sum's low bit into lo while the multiplier bits drain out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= 8'h00;
            hi    <= 8'h00;
            lo    <= 8'h00;
            count <= 4'd0;
`ifdef MUL_SIGNED_EN
            neg   <= 1'b0;
`endif
        end else if (accept) begin
            mcand <= a_load;
            lo    <= b_load;
            hi    <= 8'h00;
            count <= 4'd0;
`ifdef MUL_SIGNED_EN
            neg   <= bus.signed_op && (bus.a[7] ^ bus.b[7]);
`endif
        end else if (state == ST_RUN) begin
            {hi, lo} <= {carry_out, sum, lo[7:1]};
            count    <= count + 4'd1;
`ifdef MUL_SIGNED_EN
        end else if (state == ST_NEG) begin
            {hi, lo} <= ~{hi, lo} + 16'd1;
`endif
        end
    end

    assign bus.busy    = (state == ST_RUN) || (state == ST_NEG);
    assign bus.done    = (state == ST_DONE);
    assign bus.product = {hi, lo};

endmodule
